writeback_buffer: RTL and testbench
===================================

WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

Interface
REQ-001 SHALL take parameter REG_BITS, default from define.vh, meaning register-index width.
REQ-002 SHALL take parameter WORD_SIZE, default from define.vh (16), meaning data width.
REQ-003 SHALL take parameter WB_DEPTH, default 4, meaning load-queue entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port alu_valid  input  1  ALU result present this cycle (always accepted).
REQ-007 SHALL have port alu_reg  input  REG_BITS  ALU destination register.
REQ-008 SHALL have port alu_data  input  WORD_SIZE  ALU result.
REQ-009 SHALL have port ld_valid  input  1  load result offered.
REQ-010 SHALL have port ld_ready  output  1  queue can accept a load result.
REQ-011 SHALL have port ld_reg  input  REG_BITS  load destination register.
REQ-012 SHALL have port ld_data  input  WORD_SIZE  load data.
REQ-013 SHALL have port write_en  output  1  register-file write strobe.
REQ-014 SHALL have port write_reg  output  REG_BITS  register-file write index.
REQ-015 SHALL have port write_data  output  WORD_SIZE  register-file write data.
REQ-016 SHALL have port pending  output  2**REG_BITS  bit r set while a live queued load targets r.
REQ-017 SHALL have port count  output  clog2(WB_DEPTH)+1  queued entries (live or killed).

Function
REQ-018 Load accept SHALL occur on ld_valid && ld_ready; ld_ready SHALL equal (count < WB_DEPTH), combinational from state only.
REQ-019 Accepted load SHALL enqueue at tail as live entry {reg,data}; FIFO order preserved.
REQ-020 Per cycle arbitration: alu_valid SHALL win; else if head exists it SHALL be popped.
REQ-021 write_en/write_reg/write_data SHALL be registered: ALU result at cycle N drives write_en=1 at N+1.
REQ-022 Popped live head SHALL drive write_en=1 next cycle; popped killed head SHALL drive write_en=0 next cycle.
REQ-023 Minimum load latency SHALL be 2 cycles (enqueue N, pop N+1, write N+2); no bypass around queue.
REQ-024 Idle cycle (no ALU, empty queue) SHALL drive write_en=0; write_reg/write_data hold previous values.
REQ-025 ALU write to reg R SHALL kill every queued live entry targeting R (older load, younger ALU wins).
REQ-026 Load enqueued in same cycle as ALU write to same R SHALL enter killed.
REQ-027 Simultaneous enqueue and pop SHALL leave count unchanged; full queue with pop SHALL still report ld_ready=0 that cycle.
REQ-028 pending SHALL be combinational OR over live entries, reflecting state after the last clock edge.
REQ-029 Head/tail pointers SHALL wrap modulo WB_DEPTH; count SHALL never exceed WB_DEPTH nor underflow.
REQ-030 No register-0 special casing; all indices written as given.

Reset
REQ-031 rst_n=0 at a rising edge SHALL set write_en=0, write_reg=0, write_data=0, count=0, pointers=0, all entries killed.
REQ-032 Reset mid-operation SHALL discard queued loads without writing them; ld_ready=1 on first cycle after release.
REQ-033 Inputs during reset SHALL be ignored.

Structure
REQ-034 REG_BITS, WORD_SIZE and WB_DEPTH default SHALL live in shared define.vh.
REQ-035 Queue storage, live bits and kill logic SHALL be inline (no sub-module): kill compares alu_reg against all entries in parallel.
REQ-036 Outputs SHALL connect directly to the register file's write_en/write_reg/write_data.

Verification
REQ-037 Reset then alu_valid=1, reg 3, data 0x1234 at N -> write_en=1, write_reg=3, write_data=0x1234 at N+1 only.
REQ-038 Load reg 5 data 0xBEEF at N, no ALU -> pending[5]=1 at N+1, write 5/0xBEEF at N+2, pending[5]=0 at N+2.
REQ-039 Enqueue 4 loads back-to-back with alu_valid=1 continuously -> ld_ready=0, count=4; drop ALU -> 4 writes in enqueue order, ld_ready=1 after first pop.
REQ-040 Load reg 2 queued, then ALU reg 2 data 0x0007 -> write 2/0x0007 once; killed entry pops with write_en=0; final reg 2 = 0x0007.
REQ-041 Same-cycle ALU reg 6 and load reg 6 -> only ALU write appears; pending[6] stays 0.
REQ-042 Three loads queued, rst_n=0 one cycle -> count=0, write_en=0, no queued data ever written.

Source files
------------

// File: rtl/writeback_buffer_pkg.sv
// Shared defaults for the writeback buffer: register-index width, data
// width and load-queue depth. Other blocks import this package so the
// register file and the buffer agree on widths.
package writeback_buffer_pkg;

  localparam int unsigned WB_REG_BITS_DEF  = 4;
  localparam int unsigned WB_WORD_SIZE_DEF = 16;
  localparam int unsigned WB_DEPTH_DEF     = 4;

endpackage : writeback_buffer_pkg

// File: rtl/writeback_buffer.sv
// Writeback buffer: merges an always-accepted ALU result stream with a
// queued load-result stream into a single register-file write port.
// The ALU result has priority. A younger ALU write kills any older queued
// load to the same register, so that stale load data never reaches the file.
module writeback_buffer
  import writeback_buffer_pkg::*;
#(
  parameter int unsigned REG_BITS  = WB_REG_BITS_DEF,
  parameter int unsigned WORD_SIZE = WB_WORD_SIZE_DEF,
  parameter int unsigned WB_DEPTH  = WB_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         alu_valid,
  input  logic [REG_BITS-1:0]          alu_reg,
  input  logic [WORD_SIZE-1:0]         alu_data,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [REG_BITS-1:0]          ld_reg,
  input  logic [WORD_SIZE-1:0]         ld_data,
  output logic                         write_en,
  output logic [REG_BITS-1:0]          write_reg,
  output logic [WORD_SIZE-1:0]         write_data,
  output logic [(2**REG_BITS)-1:0]     pending,
  output logic [$clog2(WB_DEPTH):0]    count
);

  localparam int unsigned PTR_W = $clog2(WB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Queue storage; only the live bits and pointers carry reset.
  logic [REG_BITS-1:0]  ent_reg_q  [WB_DEPTH];
  logic [WORD_SIZE-1:0] ent_data_q [WB_DEPTH];
  logic [WB_DEPTH-1:0]  live_q, live_d;
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic                 write_en_q, write_en_d;
  logic [REG_BITS-1:0]  write_reg_q, write_reg_d;
  logic [WORD_SIZE-1:0] write_data_q, write_data_d;

  logic push;
  logic pop;

  // Accept depends only on registered occupancy, never on this cycle's pop.
  assign ld_ready = (count_q < CNT_W'(WB_DEPTH));
  assign push     = ld_valid && ld_ready;
  assign pop      = !alu_valid && (count_q != '0);

  assign write_en   = write_en_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign count      = count_q;

  // Next-state: arbitration, parallel kill of matching entries, enqueue, pop.
  always_comb begin
    live_d       = live_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    write_en_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;

    for (int i = 0; i < int'(WB_DEPTH); i++) begin
      if (alu_valid && (ent_reg_q[i] == alu_reg)) begin
        live_d[i] = 1'b0;
      end
    end

    if (alu_valid) begin
      write_en_d   = 1'b1;
      write_reg_d  = alu_reg;
      write_data_d = alu_data;
    end else if (pop) begin
      // A killed head is drained silently; the last written value is held.
      write_en_d = live_q[head_q];
      if (live_q[head_q]) begin
        write_reg_d  = ent_reg_q[head_q];
        write_data_d = ent_data_q[head_q];
      end
      live_d[head_q] = 1'b0;
      head_d         = head_q + PTR_W'(1);
    end

    if (push) begin
      // A load racing an ALU write to the same register is already stale.
      live_d[tail_q] = !(alu_valid && (alu_reg == ld_reg));
      tail_d         = tail_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state and registered write port, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      write_en_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      live_q       <= live_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      write_en_q   <= write_en_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  // Payload storage at the tail; contents are meaningless unless live.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      ent_reg_q[tail_q]  <= ld_reg;
      ent_data_q[tail_q] <= ld_data;
    end
  end

  // Scoreboard view: one bit per register with a live load in flight.
  always_comb begin
    pending = '0;
    for (int i = 0; i < int'(WB_DEPTH); i++) begin
      if (live_q[i]) begin
        pending[ent_reg_q[i]] = 1'b1;
      end
    end
  end

endmodule : writeback_buffer

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer with default parameters
// (REG_BITS=4, WORD_SIZE=16, WB_DEPTH=4).
module tb_writeback_buffer;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [3:0]  alu_reg;
  logic [15:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [3:0]  ld_reg;
  logic [15:0] ld_data;
  logic        write_en;
  logic [3:0]  write_reg;
  logic [15:0] write_data;
  logic [15:0] pending;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  writeback_buffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_reg    (alu_reg),
    .alu_data   (alu_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_reg     (ld_reg),
    .ld_data    (ld_data),
    .write_en   (write_en),
    .write_reg  (write_reg),
    .write_data (write_data),
    .pending    (pending),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [3:0] r, input logic [15:0] d);
    chk({tag, ".en"}, {31'd0, write_en}, {31'd0, en});
    if (en) begin
      chk({tag, ".reg"},  {28'd0, write_reg},  {28'd0, r});
      chk({tag, ".data"}, {16'd0, write_data}, {16'd0, d});
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_reg  = '0; ld_data  = '0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    // Inputs during reset must be ignored.
    ld_valid = 1'b1; ld_reg = 4'd9; ld_data = 16'h9999;
    alu_valid = 1'b1; alu_reg = 4'd9; alu_data = 16'h8888;
    tick(); tick();
    chk("rst.en",    {31'd0, write_en},   32'd0);
    chk("rst.reg",   {28'd0, write_reg},  32'd0);
    chk("rst.data",  {16'd0, write_data}, 32'd0);
    chk("rst.count", {29'd0, count},      32'd0);
    chk("rst.ready", {31'd0, ld_ready},   32'd1);
    chk("rst.pend",  {16'd0, pending},    32'd0);

    // ALU result appears on the write port one cycle later, for one cycle.
    idle_inputs();
    rst_n = 1'b1;
    alu_valid = 1'b1; alu_reg = 4'd3; alu_data = 16'h1234;
    tick();
    chk_wr("alu.w", 1'b1, 4'd3, 16'h1234);
    idle_inputs();
    tick();
    chk("alu.idle_en",   {31'd0, write_en},   32'd0);
    chk("alu.hold_reg",  {28'd0, write_reg},  32'd3);
    chk("alu.hold_data", {16'd0, write_data}, 32'h1234);

    // Single load: pending at N+1, written at N+2.
    ld_valid = 1'b1; ld_reg = 4'd5; ld_data = 16'hBEEF;
    tick();
    idle_inputs();
    chk("ld.pend1", {16'd0, pending},  32'h0020);
    chk("ld.cnt1",  {29'd0, count},    32'd1);
    chk("ld.en1",   {31'd0, write_en}, 32'd0);
    tick();
    chk_wr("ld.w", 1'b1, 4'd5, 16'hBEEF);
    chk("ld.pend2", {16'd0, pending}, 32'd0);
    chk("ld.cnt2",  {29'd0, count},   32'd0);
    tick();
    chk("ld.idle", {31'd0, write_en}, 32'd0);

    // Fill the queue while the ALU holds the port every cycle.
    alu_valid = 1'b1; alu_reg = 4'd1; alu_data = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_reg = 4'(10 + i); ld_data = 16'hA000 + 16'(i);
      tick();
    end
    chk("fill.cnt",   {29'd0, count},    32'd4);
    chk("fill.ready", {31'd0, ld_ready}, 32'd0);
    chk("fill.pend",  {16'd0, pending},  32'h3C00);
    chk_wr("fill.alu", 1'b1, 4'd1, 16'h0001);
    // Full queue: offered load must not be taken during the first pop.
    idle_inputs();
    ld_valid = 1'b1; ld_reg = 4'd15; ld_data = 16'hFFFF;
    tick();
    ld_valid = 1'b0;
    chk_wr("drain0", 1'b1, 4'd10, 16'hA000);
    chk("drain0.cnt",   {29'd0, count},    32'd3);
    chk("drain0.ready", {31'd0, ld_ready}, 32'd1);
    tick(); chk_wr("drain1", 1'b1, 4'd11, 16'hA001);
    tick(); chk_wr("drain2", 1'b1, 4'd12, 16'hA002);
    tick(); chk_wr("drain3", 1'b1, 4'd13, 16'hA003);
    chk("drain3.cnt", {29'd0, count}, 32'd0);
    tick();
    chk("drain.idle", {31'd0, write_en}, 32'd0);

    // Simultaneous enqueue and pop keeps count steady.
    ld_valid = 1'b1; ld_reg = 4'd7; ld_data = 16'h0707;
    tick();
    ld_reg = 4'd9; ld_data = 16'h0909;
    tick();
    ld_valid = 1'b0;
    chk("sim.cnt", {29'd0, count}, 32'd1);
    chk_wr("sim.w7", 1'b1, 4'd7, 16'h0707);
    tick();
    chk_wr("sim.w9", 1'b1, 4'd9, 16'h0909);

    // Younger ALU write kills an older queued load to the same register.
    idle_inputs();
    alu_valid = 1'b1; alu_reg = 4'd4; alu_data = 16'h0044;
    ld_valid = 1'b1; ld_reg = 4'd2; ld_data = 16'h5555;
    tick();
    chk("kill.pend1", {16'd0, pending}, 32'h0004);
    idle_inputs();
    alu_valid = 1'b1; alu_reg = 4'd2; alu_data = 16'h0007;
    tick();
    chk_wr("kill.alu", 1'b1, 4'd2, 16'h0007);
    chk("kill.pend2", {16'd0, pending}, 32'd0);
    chk("kill.cnt",   {29'd0, count},   32'd1);
    idle_inputs();
    tick();
    chk("kill.pop_en", {31'd0, write_en},   32'd0);
    chk("kill.cnt2",   {29'd0, count},      32'd0);
    chk("kill.final",  {16'd0, write_data}, 32'h0007);

    // Same-cycle ALU and load to one register: load enters killed.
    alu_valid = 1'b1; alu_reg = 4'd6; alu_data = 16'h0066;
    ld_valid = 1'b1; ld_reg = 4'd6; ld_data = 16'hDEAD;
    tick();
    idle_inputs();
    chk_wr("same.alu", 1'b1, 4'd6, 16'h0066);
    chk("same.pend", {16'd0, pending}, 32'd0);
    chk("same.cnt",  {29'd0, count},   32'd1);
    tick();
    chk("same.pop_en", {31'd0, write_en},   32'd0);
    chk("same.data",   {16'd0, write_data}, 32'h0066);

    // Reset with three live loads queued discards them.
    alu_valid = 1'b1; alu_reg = 4'd15; alu_data = 16'h00FF;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_reg = 4'(1 + i); ld_data = 16'h1111 * 16'(i + 1);
      tick();
    end
    chk("pre_rst.cnt", {29'd0, count}, 32'd3);
    idle_inputs();
    rst_n = 1'b0;
    ld_valid = 1'b1; ld_reg = 4'd8; ld_data = 16'h8888;
    tick();
    chk("mrst.cnt",  {29'd0, count},    32'd0);
    chk("mrst.en",   {31'd0, write_en}, 32'd0);
    chk("mrst.pend", {16'd0, pending},  32'd0);
    rst_n = 1'b1;
    ld_valid = 1'b0;
    chk("mrst.ready", {31'd0, ld_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mrst.nowrite", {31'd0, write_en}, 32'd0);
    end
    chk("mrst.cnt2", {29'd0, count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_writeback_buffer
